// File: rtl/toggle_phase_decoder.sv
// toggle_phase_decoder
//   Receive-side partner of the divide-by-2N toggle generator. Watches din,
//   locks to a toggle every HALF_PERIOD clocks and recovers the generator's
//   phase count. It pulses sync_out on an early toggle while locked. It pulses
//   err, and drops lock, when a toggle is missing.
//   Reset is asynchronous and active-low on rst.
//   Optional event counters: define TOGGLE_PHASE_DECODER_STATS_EN to build
//   sync_count / err_count. These counters saturate at 255. When the macro is
//   not defined, both ports are tied to zero.
module toggle_phase_decoder #(
   parameter int unsigned HALF_PERIOD = 4,
   parameter int unsigned CNT_W       = 4,
   parameter int unsigned LOCK_CNT    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   output logic             locked,
   output logic [CNT_W-1:0] phase,
   output logic             sync_out,
   output logic             err,
   output logic [7:0]       sync_count,
   output logic [7:0]       err_count
);

   localparam int unsigned      GOOD_W   = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(HALF_PERIOD - 1);
   localparam logic [GOOD_W-1:0] GOOD_TOP = GOOD_W'(LOCK_CNT);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      ACQ    = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t              state;
   logic                din_q;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_nxt;
   logic [GOOD_W-1:0]   good;
   logic [GOOD_W-1:0]   good_inc;
   logic                din_edge;
   logic                at_top;
   logic                tracking;
   logic                is_good;
   logic                is_early;
   logic                is_late;

   // Edge detect, interval classification and next interval count
   always_comb begin
      din_edge = din ^ din_q;
      at_top   = (cnt == CNT_TOP);
      tracking = (state != HUNT);
      is_good  = tracking &  din_edge &  at_top;
      is_early = tracking &  din_edge & ~at_top;
      is_late  = tracking & ~din_edge &  at_top;
      good_inc = good + 1'b1;
      // Holding at the top is only reachable in HUNT: in ACQ/LOCKED the same
      // condition is a late toggle, which sends the FSM back to HUNT anyway.
      if (din_edge)
         cnt_nxt = '0;
      else if (at_top)
         cnt_nxt = cnt;
      else
         cnt_nxt = cnt + 1'b1;
   end

   // Cadence FSM with registered lock, phase and event pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= HUNT;
         din_q    <= 1'b0;
         cnt      <= '0;
         good     <= '0;
         locked   <= 1'b0;
         phase    <= '0;
         sync_out <= 1'b0;
         err      <= 1'b0;
      end else begin
         din_q    <= din;
         cnt      <= cnt_nxt;
         sync_out <= 1'b0;
         err      <= 1'b0;
         case (state)
            HUNT: begin
               if (din_edge) begin
                  state <= ACQ;
                  good  <= '0;
               end
            end
            ACQ: begin
               if (is_good) begin
                  good <= good_inc;
                  if (good_inc == GOOD_TOP) begin
                     state  <= LOCKED;
                     locked <= 1'b1;
                     phase  <= cnt_nxt;
                  end
               end else if (is_early) begin
                  good <= '0;
               end else if (is_late) begin
                  err   <= 1'b1;
                  state <= HUNT;
               end
            end
            LOCKED: begin
               phase <= cnt_nxt;
               if (is_early) begin
                  sync_out <= 1'b1;
               end else if (is_late) begin
                  err    <= 1'b1;
                  state  <= HUNT;
                  locked <= 1'b0;
                  phase  <= '0;
               end
            end
            default: begin
               state  <= HUNT;
               locked <= 1'b0;
               phase  <= '0;
            end
         endcase
      end
   end

`ifdef TOGGLE_PHASE_DECODER_STATS_EN
   logic sync_evt;

   always_comb sync_evt = is_early & (state == LOCKED);

   // Saturating early/missing toggle counters, bumped with their pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_count <= '0;
         err_count  <= '0;
      end else begin
         if (sync_evt && (sync_count != 8'hFF))
            sync_count <= sync_count + 1'b1;
         if (is_late && (err_count != 8'hFF))
            err_count <= err_count + 1'b1;
      end
   end
`else
   assign sync_count = '0;
   assign err_count  = '0;
`endif

endmodule
